// File: rtl/clock_divider_prog.sv
// Programmable clock divider. Divisor updates are double-buffered and take effect only
// at a period boundary, or at any edge while idle.
module clock_divider_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             upd_pend
);

    localparam logic [WIDTH-1:0] DivReset = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             upd_q, upd_d;

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] last;

    always_comb begin
        load_val = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
        cnt_inc  = cnt_q + 1'b1;
        half     = div_q - (div_q >> 1);
        last     = div_q - 1'b1;

        state_d = state_q;
        cnt_d   = cnt_q;
        clk_d   = 1'b0;
        tick_d  = 1'b0;
        div_d   = div_q;
        pend_d  = pend_q;
        upd_d   = upd_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (upd_q) begin
                    div_d = pend_q;
                    upd_d = 1'b0;
                end
                // Divisor is always >= 2, so the first cycle of a run never carries tick.
                if (en) begin
                    state_d = StRun;
                    clk_d   = 1'b1;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == last) begin
                    cnt_d = '0;
                    clk_d = 1'b1;
                    if (upd_q) begin
                        div_d = pend_q;
                        upd_d = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_inc;
                    clk_d  = (cnt_inc < half);
                    tick_d = (cnt_inc == last);
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh load lands after any application above, so it always stays pending.
        if (div_load) begin
            pend_d = load_val;
            upd_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            div_q   <= DivReset;
            pend_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            upd_q   <= upd_d;
        end
    end

    assign clk_out    = clk_q;
    assign tick       = tick_q;
    assign div_active = div_q;
    assign upd_pend   = upd_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scenario bench for clock_divider_prog: each task queues per-cycle stimulus with the
// expected registered outputs, then drives it and compares after every rising edge.
module tb_clock_divider_prog;

    localparam int unsigned W = 8;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] div_active;
    logic         upd_pend;

    typedef logic [W+2:0] vec_t;  // {clk_out, tick, upd_pend, div_active}
    typedef struct {
        bit    r;
        bit    e;
        bit    l;
        int    din;
        string name;
        vec_t  v;
    } stim_t;

    stim_t       stim_q[$];
    stim_t       exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    clock_divider_prog #(
        .WIDTH      (W),
        .DEFAULT_DIV(4)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .div_in    (div_in),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .tick      (tick),
        .div_active(div_active),
        .upd_pend  (upd_pend)
    );

    always #5 clk_in = ~clk_in;

    // Output for position p of a period of length d: high for ceil(d/2), tick on the last.
    function automatic vec_t pat(input int d, input int p, input bit upd);
        logic [W-1:0] dv;
        dv = d[W-1:0];
        return {(p < (d - d / 2)), (p == d - 1), upd, dv};
    endfunction

    function automatic vec_t idle(input int d, input bit upd);
        logic [W-1:0] dv;
        dv = d[W-1:0];
        return {1'b0, 1'b0, upd, dv};
    endfunction

    task automatic add(input bit r, input bit e, input bit l, input int din, input string nm,
                       input vec_t v);
        stim_t s;
        s.r = r; s.e = e; s.l = l; s.din = din; s.name = nm; s.v = v;
        stim_q.push_back(s);
    endtask

    task automatic test_reset();
        stim_t s, x;
        for (int k = 0; k < 2; k++) add(0, 1, 1, 9, $sformatf("reset[%0d]", k), idle(4, 0));
        add(1, 0, 0, 0, "reset_release", idle(4, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_n = s.r; en = s.e; div_load = s.l; div_in = s.din[W-1:0];
            exp_q.push_back(s);
            @(posedge clk_in); #1;
            x = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, upd_pend, div_active} !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (clk_out,tick,upd_pend,div_active)", x.name,
                         {clk_out, tick, upd_pend, div_active}, x.v);
            end
        end
    endtask

    task automatic test_default();
        stim_t s, x;
        for (int k = 0; k < 12; k++) add(1, 1, 0, 0, $sformatf("def4[%0d]", k), pat(4, k % 4, 0));
        add(1, 0, 0, 0, "def4_stop", idle(4, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_n = s.r; en = s.e; div_load = s.l; div_in = s.din[W-1:0];
            exp_q.push_back(s);
            @(posedge clk_in); #1;
            x = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, upd_pend, div_active} !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (clk_out,tick,upd_pend,div_active)", x.name,
                         {clk_out, tick, upd_pend, div_active}, x.v);
            end
        end
    endtask

    task automatic test_odd();
        stim_t s, x;
        add(1, 0, 1, 5, "odd_load", idle(4, 1));
        add(1, 0, 0, 0, "odd_apply", idle(5, 0));
        for (int k = 0; k < 10; k++) add(1, 1, 0, 0, $sformatf("odd5[%0d]", k), pat(5, k % 5, 0));
        add(1, 0, 0, 0, "odd_stop", idle(5, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_n = s.r; en = s.e; div_load = s.l; div_in = s.din[W-1:0];
            exp_q.push_back(s);
            @(posedge clk_in); #1;
            x = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, upd_pend, div_active} !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (clk_out,tick,upd_pend,div_active)", x.name,
                         {clk_out, tick, upd_pend, div_active}, x.v);
            end
        end
    endtask

    task automatic test_mid_update();
        stim_t s, x;
        add(1, 0, 1, 4, "mid_load4", idle(5, 1));
        add(1, 0, 0, 0, "mid_apply4", idle(4, 0));
        for (int k = 0; k < 16; k++) begin
            if (k < 4) add(1, 1, k == 1, 6, $sformatf("mid[%0d]", k), pat(4, k, k >= 1));
            else       add(1, 1, 0, 0, $sformatf("mid[%0d]", k), pat(6, (k - 4) % 6, 0));
        end
        add(1, 0, 0, 0, "mid_stop", idle(6, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_n = s.r; en = s.e; div_load = s.l; div_in = s.din[W-1:0];
            exp_q.push_back(s);
            @(posedge clk_in); #1;
            x = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, upd_pend, div_active} !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (clk_out,tick,upd_pend,div_active)", x.name,
                         {clk_out, tick, upd_pend, div_active}, x.v);
            end
        end
    endtask

    task automatic test_clamp();
        stim_t s, x;
        add(1, 0, 1, 0, "clamp_load0", idle(6, 1));
        add(1, 0, 1, 1, "clamp_load1", idle(2, 1));
        for (int k = 0; k < 9; k++) add(1, 1, 0, 0, $sformatf("clamp2[%0d]", k), pat(2, k % 2, 0));
        add(1, 0, 0, 0, "clamp_stop", idle(2, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_n = s.r; en = s.e; div_load = s.l; div_in = s.din[W-1:0];
            exp_q.push_back(s);
            @(posedge clk_in); #1;
            x = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, upd_pend, div_active} !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (clk_out,tick,upd_pend,div_active)", x.name,
                         {clk_out, tick, upd_pend, div_active}, x.v);
            end
        end
    endtask

    task automatic test_enable_drop();
        stim_t s, x;
        add(1, 0, 1, 4, "drop_load4", idle(2, 1));
        add(1, 0, 0, 0, "drop_apply4", idle(4, 0));
        for (int k = 0; k < 2; k++) add(1, 1, 0, 0, $sformatf("drop_run[%0d]", k), pat(4, k, 0));
        for (int k = 0; k < 3; k++) add(1, 0, 0, 0, $sformatf("drop_idle[%0d]", k), idle(4, 0));
        for (int k = 0; k < 8; k++) add(1, 1, 0, 0, $sformatf("drop_re[%0d]", k), pat(4, k % 4, 0));
        add(1, 0, 0, 0, "drop_stop", idle(4, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_n = s.r; en = s.e; div_load = s.l; div_in = s.din[W-1:0];
            exp_q.push_back(s);
            @(posedge clk_in); #1;
            x = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, upd_pend, div_active} !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (clk_out,tick,upd_pend,div_active)", x.name,
                         {clk_out, tick, upd_pend, div_active}, x.v);
            end
        end
    endtask

    // Last-wins overwrite, then a load coinciding with the period boundary.
    task automatic test_back_to_back();
        stim_t s, x;
        for (int k = 0; k < 16; k++) begin
            string nm;
            nm = $sformatf("b2b[%0d]", k);
            if (k < 4)       add(1, 1, k == 1 || k == 2, (k == 1) ? 3 : 7, nm, pat(4, k, k >= 1));
            else if (k < 11) add(1, 1, k == 4, 5, nm, pat(7, k - 4, 1));
            else             add(1, 1, 0, 0, nm, pat(5, k - 11, 0));
        end
        add(1, 0, 0, 0, "b2b_stop", idle(5, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_n = s.r; en = s.e; div_load = s.l; div_in = s.din[W-1:0];
            exp_q.push_back(s);
            @(posedge clk_in); #1;
            x = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, upd_pend, div_active} !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (clk_out,tick,upd_pend,div_active)", x.name,
                         {clk_out, tick, upd_pend, div_active}, x.v);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s, x;
        add(1, 1, 1, 6, "rmid_start", pat(5, 0, 1));
        add(1, 1, 0, 0, "rmid_run", pat(5, 1, 1));
        add(0, 1, 0, 0, "rmid_reset", idle(4, 0));
        add(1, 0, 0, 0, "rmid_idle", idle(4, 0));
        for (int k = 0; k < 8; k++) add(1, 1, 0, 0, $sformatf("rmid4[%0d]", k), pat(4, k % 4, 0));
        add(1, 0, 0, 0, "rmid_stop", idle(4, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_n = s.r; en = s.e; div_load = s.l; div_in = s.din[W-1:0];
            exp_q.push_back(s);
            @(posedge clk_in); #1;
            x = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, upd_pend, div_active} !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (clk_out,tick,upd_pend,div_active)", x.name,
                         {clk_out, tick, upd_pend, div_active}, x.v);
            end
        end
    endtask

    task automatic test_max_div();
        stim_t s, x;
        add(1, 0, 1, 255, "max_load", idle(4, 1));
        add(1, 0, 0, 0, "max_apply", idle(255, 0));
        for (int k = 0; k < 260; k++)
            add(1, 1, 0, 0, $sformatf("max[%0d]", k), pat(255, k % 255, 0));
        add(1, 0, 0, 0, "max_stop", idle(255, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst_n = s.r; en = s.e; div_load = s.l; div_in = s.din[W-1:0];
            exp_q.push_back(s);
            @(posedge clk_in); #1;
            x = exp_q.pop_front();
            n_cmp++;
            if ({clk_out, tick, upd_pend, div_active} !== x.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (clk_out,tick,upd_pend,div_active)", x.name,
                         {clk_out, tick, upd_pend, div_active}, x.v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = '0;
        test_reset();
        test_default();
        test_odd();
        test_mid_update();
        test_clamp();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid();
        test_max_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_divider_prog.md
CLOCK_DIVIDER_PROG -- requirements
Module: clock_divider_prog

Interface
REQ-001 Parameter WIDTH, default 8: width of divisor ports and the internal period counter.
REQ-002 Parameter DEFAULT_DIV, default 4: divisor loaded at reset; values below 2 are clamped to 2.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  run enable; 1 = generate output, 0 = idle.
REQ-006 div_in  input  WIDTH  requested divisor (output period in clk_in cycles).
REQ-007 div_load  input  1  single-cycle strobe; captures div_in as the pending divisor.
REQ-008 clk_out  output  1  registered divided clock.
REQ-009 tick  output  1  registered, high during the last clk_in cycle of each clk_out period.
REQ-010 div_active  output  WIDTH  divisor currently in effect (D).
REQ-011 upd_pend  output  1  a loaded divisor is waiting to take effect.

Function
REQ-012 Two-state FSM, IDLE and RUN; counter cnt (WIDTH bits) counts 0..D-1 in RUN.
REQ-013 High-phase length H = D - floor(D/2), i.e. ceil(D/2); low phase = floor(D/2); period exactly D cycles for all D >= 2.
REQ-014 Values of div_in below 2 (0 or 1) are clamped to 2 when captured.
REQ-015 IDLE: cnt = 0, clk_out = 0, tick = 0; a pending divisor is applied at every edge spent in IDLE.
REQ-016 IDLE with en = 1 at an edge: go to RUN, cnt <= 0, clk_out <= 1 (first high cycle is the cycle after that edge).
REQ-017 RUN with en = 1: cnt <= (cnt == D-1) ? 0 : cnt + 1; clk_out <= (next cnt < H); tick <= (next cnt == D-1).
REQ-018 RUN with en = 0 at an edge: go to IDLE the same edge; clk_out <= 0, tick <= 0, cnt <= 0 (period truncated, no glitch beyond a single registered transition).
REQ-019 div_load = 1: pending <= clamp(div_in), upd_pend <= 1; a later load before application overwrites pending (last wins).
REQ-020 Application point: in RUN, the edge where cnt == D-1 and en = 1 (period boundary); D <= pending, upd_pend <= 0; the next period uses the new D and H.
REQ-021 Simultaneous div_load and application edge: the previously pending value (if any) is applied; the newly loaded value becomes pending with upd_pend = 1. If nothing was pending, D is unchanged and the new value becomes pending.
REQ-022 Simultaneous div_load and IDLE->RUN edge: treated as in REQ-021; the run starts with the prior pending value or current D.
REQ-023 D never changes mid-period; clk_out high and low phases are never shortened by a divisor update.
REQ-024 tick and clk_out are both registered; no combinational path from any input to any output.
REQ-025 Maximum divisor 2^WIDTH - 1; counter arithmetic is WIDTH bits with no overflow at D-1.

Reset
REQ-026 On a rising edge with rst_n = 0: state = IDLE, cnt = 0, clk_out = 0, tick = 0, D = clamp(DEFAULT_DIV), pending cleared, upd_pend = 0; reset overrides en and div_load.
REQ-027 Reset asserted mid-period aborts the period; first edge after rst_n = 1 behaves per REQ-015/REQ-016.

Verification
REQ-028 Reset, en = 1, default D = 4: clk_out 1,1,0,0 repeating, tick high on every 4th cycle aligned to the second low cycle.
REQ-029 Odd divisor: load 5 in IDLE, en = 1: clk_out 1,1,1,0,0 repeating, period 5, tick on the 5th cycle.
REQ-030 Mid-run update: D = 4 running, load 6 at cnt = 1: upd_pend = 1 until the boundary edge; current period completes as 4, then 1,1,1,0,0,0; div_active reads 6 afterward.
REQ-031 Clamp: load 0 then 1, en = 1: div_active = 2, clk_out toggles every cycle (1,0,...), tick every 2nd cycle.
REQ-032 Enable drop at cnt = 1 with D = 4: clk_out 0 at the next cycle, tick never asserted; re-raising en restarts at cnt = 0 with clk_out = 1.
REQ-033 Reset mid-operation with D = 6 loaded: after reset, div_active = 4, upd_pend = 0, outputs 0, and normal D = 4 operation resumes on en.
